// File: rtl/vid_timing_gen.sv
// 720x480p video timing generator: qualifies the PLL lock, then produces sync,
// blanking, data-enable and pixel coordinates, all registered and aligned to x/y.
module vid_timing_gen #(
  parameter int unsigned H_ACTIVE  = 720,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 62,
  parameter int unsigned H_BP      = 60,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 9,
  parameter int unsigned V_SYNC    = 6,
  parameter int unsigned V_BP      = 30,
  parameter bit          HS_POL    = 1'b0,
  parameter bit          VS_POL    = 1'b0,
  parameter int unsigned LOCK_WAIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pll_locked,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic        hblank,
  output logic        vblank,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        frame_start,
  output logic        line_start,
  output logic        running
);

  localparam int unsigned CW      = 12;
  localparam int unsigned WW      = 16;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(LOCK_WAIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RUN
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [WW-1:0] wcnt;
  logic [WW-1:0] wcnt_nx;
  logic          lk_meta;
  logic          lk_s;

  logic          adv;
  logic [CW-1:0] x_nx;
  logic [CW-1:0] y_nx;
  logic          hs_act;
  logic          vs_act;

  // Two-flop synchronizer for the asynchronous lock flag
  always_ff @(posedge clk) begin
    if (rst) begin
      lk_meta <= 1'b0;
      lk_s    <= 1'b0;
    end else begin
      lk_meta <= pll_locked;
      lk_s    <= lk_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
    end
  end

  // Lock qualification: any drop of lk_s restarts the full wait period
  always_comb begin
    state_nx = state;
    wcnt_nx  = '0;
    case (state)
      ST_IDLE: begin
        if (lk_s) state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (!lk_s) begin
          state_nx = ST_IDLE;
        end else if (wcnt == WAIT_LAST) begin
          state_nx = ST_RUN;
        end else begin
          wcnt_nx = wcnt + WW'(1);
        end
      end
      ST_RUN: begin
        if (!lk_s) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Next raster position; the first advancing cycle after entry starts at 0,0
  always_comb begin
    adv  = (state == ST_RUN) && lk_s;
    x_nx = '0;
    y_nx = '0;
    if (adv && running) begin
      if (x == H_LAST) begin
        x_nx = '0;
        y_nx = (y == V_LAST) ? '0 : y + CW'(1);
      end else begin
        x_nx = x + CW'(1);
        y_nx = y;
      end
    end
  end

  assign hs_act = (x_nx >= H_SYNC_BEG) && (x_nx < H_SYNC_END);
  assign vs_act = (y_nx >= V_SYNC_BEG) && (y_nx < V_SYNC_END);

  // Flags are derived from the next position so they land on the same cycle as x/y
  always_ff @(posedge clk) begin
    if (rst || !adv) begin
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      hblank      <= 1'b1;
      vblank      <= 1'b1;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      running     <= 1'b0;
    end else begin
      x           <= x_nx;
      y           <= y_nx;
      de          <= (x_nx < H_ACT_END) && (y_nx < V_ACT_END);
      hblank      <= (x_nx >= H_ACT_END);
      vblank      <= (y_nx >= V_ACT_END);
      hs          <= hs_act ? HS_POL : ~HS_POL;
      vs          <= vs_act ? VS_POL : ~VS_POL;
      line_start  <= (x_nx == '0);
      frame_start <= (x_nx == '0) && (y_nx == '0);
      running     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vid_timing_gen.sv
// Bench for vid_timing_gen: a small-geometry instance and a default 858x525 instance
// share clock, reset and lock, checked against a cycle-index reference model.
module tb_vid_timing_gen;

  localparam int SH_A = 20, SH_F = 3, SH_S = 4, SH_B = 5;
  localparam int SV_A = 10, SV_F = 2, SV_S = 3, SV_B = 4;
  localparam int S_LW = 4;
  localparam bit S_HP = 1'b1, S_VP = 1'b0;
  localparam int S_HT = SH_A + SH_F + SH_S + SH_B;
  localparam int S_VT = SV_A + SV_F + SV_S + SV_B;

  localparam int BH_A = 720, BH_F = 16, BH_S = 62, BH_B = 60;
  localparam int BV_A = 480, BV_F = 9, BV_S = 6, BV_B = 30;
  localparam int B_LW = 1024;
  localparam int B_HT = BH_A + BH_F + BH_S + BH_B;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        hblank;
    logic        vblank;
    logic [11:0] x;
    logic [11:0] y;
    logic        fs;
    logic        ls;
    logic        running;
  } out_t;

  typedef struct {
    bit r;
    bit p;
    int n;
    bit run;
    int x;
    int y;
    bit fs;
  } vec_t;

  logic clk;
  logic rst;
  logic pll_locked;

  logic s_hs, s_vs, s_de, s_hb, s_vb, s_fs, s_ls, s_run;
  logic [11:0] s_x, s_y;
  logic b_hs, b_vs, b_de, b_hb, b_vb, b_fs, b_ls, b_run;
  logic [11:0] b_x, b_y;
  out_t s_o, b_o;

  assign s_o = {s_hs, s_vs, s_de, s_hb, s_vb, s_x, s_y, s_fs, s_ls, s_run};
  assign b_o = {b_hs, b_vs, b_de, b_hb, b_vb, b_x, b_y, b_fs, b_ls, b_run};

  vid_timing_gen #(
    .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
    .HS_POL(S_HP), .VS_POL(S_VP), .LOCK_WAIT(S_LW)
  ) dut_s (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .hs(s_hs), .vs(s_vs), .de(s_de), .hblank(s_hb), .vblank(s_vb),
    .x(s_x), .y(s_y), .frame_start(s_fs), .line_start(s_ls), .running(s_run)
  );

  vid_timing_gen dut_b (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .hs(b_hs), .vs(b_vs), .de(b_de), .hblank(b_hb), .vblank(b_vb),
    .x(b_x), .y(b_y), .frame_start(b_fs), .line_start(b_ls), .running(b_run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int edge_no = 0;

  // Reference state: lock-qualification streak history and raster index per instance
  int streak0 = 0, streak1 = 0, streak2 = 0;
  bit rst_prev = 1'b1;
  bit m_s_run = 1'b0, m_b_run = 1'b0;
  int m_s_n = 0, m_b_n = 0;
  out_t s_exp, b_exp;

  function automatic out_t ref_out(input bit run, input int n,
                                   input int ha, input int hf, input int hsw, input int hb,
                                   input int va, input int vf, input int vsw, input int vb,
                                   input bit hp, input bit vp);
    out_t o;
    int ht, vt, px, py;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    if (!run) begin
      o = '{hs: !hp, vs: !vp, de: 1'b0, hblank: 1'b1, vblank: 1'b1,
            x: 12'd0, y: 12'd0, fs: 1'b0, ls: 1'b0, running: 1'b0};
    end else begin
      px = n % ht;
      py = (n / ht) % vt;
      o.x       = 12'(px);
      o.y       = 12'(py);
      o.de      = (px < ha) && (py < va);
      o.hblank  = (px >= ha);
      o.vblank  = (py >= va);
      o.hs      = (px >= ha + hf && px < ha + hf + hsw) ? hp : !hp;
      o.vs      = (py >= va + vf && py < va + vf + vsw) ? vp : !vp;
      o.ls      = (px == 0);
      o.fs      = (px == 0) && (py == 0);
      o.running = 1'b1;
    end
    return o;
  endfunction

  // Output is live once lock has been seen high for LOCK_WAIT+2 consecutive
  // samples ending two edges back, with no reset in the last two edges.
  task automatic model_edge(input bit r, input bit p);
    bit now_s, now_b;
    streak2 = streak1;
    streak1 = streak0;
    streak0 = (p && !r) ? streak0 + 1 : 0;
    now_s = !r && !rst_prev && (streak2 >= S_LW + 2);
    now_b = !r && !rst_prev && (streak2 >= B_LW + 2);
    m_s_n = (now_s && m_s_run) ? m_s_n + 1 : 0;
    m_b_n = (now_b && m_b_run) ? m_b_n + 1 : 0;
    m_s_run = now_s;
    m_b_run = now_b;
    rst_prev = r;
    s_exp = ref_out(m_s_run, m_s_n, SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, S_HP, S_VP);
    b_exp = ref_out(m_b_run, m_b_n, BH_A, BH_F, BH_S, BH_B, BV_A, BV_F, BV_S, BV_B, 1'b0, 1'b0);
  endtask

  task automatic check_out(input string name, input out_t got, input out_t want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s edge %0d: got hs=%b vs=%b de=%b hbl=%b vbl=%b x=%0d y=%0d fs=%b ls=%b run=%b; want hs=%b vs=%b de=%b hbl=%b vbl=%b x=%0d y=%0d fs=%b ls=%b run=%b",
               name, edge_no, got.hs, got.vs, got.de, got.hblank, got.vblank, got.x, got.y,
               got.fs, got.ls, got.running, want.hs, want.vs, want.de, want.hblank,
               want.vblank, want.x, want.y, want.fs, want.ls, want.running);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s edge %0d: got %0d, want %0d", name, edge_no, got, want);
    end
  endtask

  // One clock: drive while clk is low, model at the edge, compare on the falling edge
  task automatic tick(input bit r, input bit p);
    rst = r;
    pll_locked = p;
    @(posedge clk);
    model_edge(r, p);
    edge_no++;
    @(negedge clk);
    check_out("small", s_o, s_exp);
    check_out("big", b_o, b_exp);
  endtask

  vec_t tbl[20];

  int fs_seen = 0, last_fs = 0;
  int acc_de = 0, acc_ls = 0, acc_vs = 0, vs_bad = 0;
  logic vs_prev = 1'b1;
  bit prev_run = 1'b0;
  int bde = 0, bhs = 0, bhb = 0, bhs_first = -1;

  initial begin
    rst = 1'b1;
    pll_locked = 1'b0;

    // {rst, pll_locked, cycles, expected running/x/y/frame_start after the segment}
    tbl[0]  = '{1'b1, 1'b0,   2, 1'b0,  0, 0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1,   7, 1'b0,  0, 0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1,   1, 1'b1,  0, 0, 1'b1};
    tbl[3]  = '{1'b0, 1'b1,  32, 1'b1,  0, 1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 576, 1'b1,  0, 0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1,  45, 1'b1, 13, 1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0,   2, 1'b1, 15, 1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0,   1, 1'b0,  0, 0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1,   7, 1'b0,  0, 0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1,   1, 1'b1,  0, 0, 1'b1};
    tbl[10] = '{1'b1, 1'b1,   1, 1'b0,  0, 0, 1'b0};
    tbl[11] = '{1'b0, 1'b1,   8, 1'b1,  0, 0, 1'b1};
    tbl[12] = '{1'b0, 1'b0,  10, 1'b0,  0, 0, 1'b0};
    tbl[13] = '{1'b0, 1'b1,   2, 1'b0,  0, 0, 1'b0};
    tbl[14] = '{1'b0, 1'b0,  10, 1'b0,  0, 0, 1'b0};
    tbl[15] = '{1'b0, 1'b1,   5, 1'b0,  0, 0, 1'b0};
    tbl[16] = '{1'b0, 1'b0,   6, 1'b0,  0, 0, 1'b0};
    tbl[17] = '{1'b0, 1'b1,   6, 1'b0,  0, 0, 1'b0};
    tbl[18] = '{1'b0, 1'b0,   2, 1'b1,  0, 0, 1'b1};
    tbl[19] = '{1'b0, 1'b0,   1, 1'b0,  0, 0, 1'b0};

    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < tbl[i].n; k++) tick(tbl[i].r, tbl[i].p);
      check_int($sformatf("tbl%0d_running", i), int'(s_run), int'(tbl[i].run));
      check_int($sformatf("tbl%0d_x", i), int'(s_x), tbl[i].x);
      check_int($sformatf("tbl%0d_y", i), int'(s_y), tbl[i].y);
      check_int($sformatf("tbl%0d_frame_start", i), int'(s_fs), int'(tbl[i].fs));
    end

    // Long lock: whole small frames plus the first line of the default geometry
    for (int i = 0; i < 1900; i++) begin
      tick(1'b0, 1'b1);
      if (s_fs === 1'b1) begin
        if (fs_seen > 0) begin
          check_int("frame_period", edge_no - last_fs, S_HT * S_VT);
          check_int("frame_de", acc_de, SH_A * SV_A);
          check_int("frame_line_starts", acc_ls, S_VT);
          check_int("frame_vs_cycles", acc_vs, SV_S * S_HT);
          check_int("vs_edge_off_x0", vs_bad, 0);
        end
        fs_seen++;
        last_fs = edge_no;
        acc_de = 0;
        acc_ls = 0;
        acc_vs = 0;
        vs_bad = 0;
      end
      if (s_run === 1'b1) begin
        acc_de += int'(s_de);
        acc_ls += int'(s_ls);
        acc_vs += (s_vs === S_VP) ? 1 : 0;
        if (prev_run && s_vs !== vs_prev && s_x != 12'd0) vs_bad++;
      end
      vs_prev = s_vs;
      prev_run = (s_run === 1'b1);
      if (m_b_run && m_b_n < B_HT) begin
        bde += int'(b_de);
        bhb += int'(b_hb);
        if (b_hs === 1'b0) begin
          bhs++;
          if (bhs_first < 0) bhs_first = int'(b_x);
        end
      end
    end
    check_int("frames_seen", (fs_seen >= 4) ? 1 : 0, 1);
    check_int("big_line0_de", bde, BH_A);
    check_int("big_line0_hs_low", bhs, BH_S);
    check_int("big_line0_hs_first_x", bhs_first, BH_A + BH_F);
    check_int("big_line0_hblank", bhb, BH_F + BH_S + BH_B);

    // Random lock toggles and occasional resets against the reference model
    begin
      bit p;
      bit r;
      p = 1'b1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(59, 0) == 0) p = !p;
        r = ($urandom_range(299, 0) == 0);
        tick(r, p);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
